// File: rtl/tanimlamalar_pkg.sv
// Shared definitions for the execute-stage ALU and the decoder:
// opcode codes, opcode width, data width and shifter modes.
package tanimlamalar;

  localparam int AMB_VERI_GENISLIGI    = 32;
  localparam int AMB_KONTROL_GENISLIGI = 4;

  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_TOPLAMA = 4'd0;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_CIKARMA = 4'd1;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_XOR     = 4'd2;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_OR      = 4'd3;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_AND     = 4'd4;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_SLL     = 4'd5;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_SRL     = 4'd6;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_SRA     = 4'd7;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_SLT     = 4'd8;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_SLTU    = 4'd9;
  localparam logic [AMB_KONTROL_GENISLIGI-1:0] AMB_GECIR   = 4'd10;

  typedef enum logic [1:0] {
    KAYDIR_SOL            = 2'd0,
    KAYDIR_SAG_MANTIK     = 2'd1,
    KAYDIR_SAG_ARITMETIK  = 2'd2
  } kaydirma_modu_t;

endpackage

// File: rtl/amb_kaydirici.sv
// 32-bit barrel shifter for SLL/SRL/SRA; the amount is already reduced
// to 5 bits by the caller.
module amb_kaydirici
  import tanimlamalar::*;
(
  input  logic [AMB_VERI_GENISLIGI-1:0] deger_i,
  input  logic [4:0]                    miktar_i,
  input  kaydirma_modu_t                mod_i,
  output logic [AMB_VERI_GENISLIGI-1:0] sonuc_o
);

  always_comb begin
    sonuc_o = '0;
    case (mod_i)
      KAYDIR_SOL:           sonuc_o = deger_i << miktar_i;
      KAYDIR_SAG_MANTIK:    sonuc_o = deger_i >> miktar_i;
      KAYDIR_SAG_ARITMETIK: sonuc_o = $unsigned($signed(deger_i) >>> miktar_i);
      default:              sonuc_o = '0;
    endcase
  end

endmodule

// File: rtl/aritmetik_mantik_birimi.sv
// RV32I-style integer ALU: combinational result plus a one-cycle registered
// copy with a valid bit. Define AMB_BAYRAK_EN to add sifir_o/esit_o flags.
module aritmetik_mantik_birimi
  import tanimlamalar::*;
#(
  parameter int VERI_GENISLIGI = AMB_VERI_GENISLIGI
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [AMB_KONTROL_GENISLIGI-1:0] kontrol_i,
  input  logic [VERI_GENISLIGI-1:0]        deger1_i,
  input  logic [VERI_GENISLIGI-1:0]        deger2_i,
  input  logic                             gecerli_i,
  output logic [VERI_GENISLIGI-1:0]        sonuc_o,
  output logic [VERI_GENISLIGI-1:0]        sonuc_kayit_o,
`ifdef AMB_BAYRAK_EN
  output logic                             sifir_o,
  output logic                             esit_o,
`endif
  output logic                             gecerli_o
);

  logic [VERI_GENISLIGI-1:0] w_toplam;
  logic [VERI_GENISLIGI-1:0] w_fark;
  logic [VERI_GENISLIGI-1:0] w_kaydirilmis;
  logic                      w_kucuk_isaretli;
  logic                      w_kucuk_isaretsiz;
  kaydirma_modu_t            w_kaydirma_modu;

  logic [VERI_GENISLIGI-1:0] r_sonuc_kayit;
  logic                      r_gecerli;

  assign w_toplam          = deger1_i + deger2_i;
  assign w_fark            = deger1_i - deger2_i;
  assign w_kucuk_isaretli  = $signed(deger1_i) < $signed(deger2_i);
  assign w_kucuk_isaretsiz = deger1_i < deger2_i;

  always_comb begin
    w_kaydirma_modu = KAYDIR_SOL;
    case (kontrol_i)
      AMB_SRL: w_kaydirma_modu = KAYDIR_SAG_MANTIK;
      AMB_SRA: w_kaydirma_modu = KAYDIR_SAG_ARITMETIK;
      default: w_kaydirma_modu = KAYDIR_SOL;
    endcase
  end

  // Only the low five bits of operand 2 select the shift distance.
  amb_kaydirici u_kaydirici (
    .deger_i  (deger1_i),
    .miktar_i (deger2_i[4:0]),
    .mod_i    (w_kaydirma_modu),
    .sonuc_o  (w_kaydirilmis)
  );

  always_comb begin
    sonuc_o = '0;
    case (kontrol_i)
      AMB_TOPLAMA: sonuc_o = w_toplam;
      AMB_CIKARMA: sonuc_o = w_fark;
      AMB_XOR:     sonuc_o = deger1_i ^ deger2_i;
      AMB_OR:      sonuc_o = deger1_i | deger2_i;
      AMB_AND:     sonuc_o = deger1_i & deger2_i;
      AMB_SLL,
      AMB_SRL,
      AMB_SRA:     sonuc_o = w_kaydirilmis;
      AMB_SLT:     sonuc_o = {{(VERI_GENISLIGI-1){1'b0}}, w_kucuk_isaretli};
      AMB_SLTU:    sonuc_o = {{(VERI_GENISLIGI-1){1'b0}}, w_kucuk_isaretsiz};
      AMB_GECIR:   sonuc_o = deger2_i;
      default:     sonuc_o = '0;
    endcase
  end

  // Shadow stage: the result is held while no new valid operands arrive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sonuc_kayit <= '0;
      r_gecerli     <= 1'b0;
    end else begin
      r_gecerli <= gecerli_i;
      if (gecerli_i) begin
        r_sonuc_kayit <= sonuc_o;
      end
    end
  end

  assign sonuc_kayit_o = r_sonuc_kayit;
  assign gecerli_o     = r_gecerli;

`ifdef AMB_BAYRAK_EN
  assign sifir_o = (sonuc_o == '0);
  assign esit_o  = (deger1_i == deger2_i);
`endif

endmodule

// File: tb/tb_aritmetik_mantik_birimi.sv
// Scoreboard bench for aritmetik_mantik_birimi: directed vectors push the
// expected registered result, a monitor pops it whenever gecerli_o is high.
`timescale 1ns/1ps
module tb_aritmetik_mantik_birimi;
  import tanimlamalar::*;

  logic        clk;
  logic        rst;
  logic [3:0]  kontrol;
  logic [31:0] deger1;
  logic [31:0] deger2;
  logic        gecerliIn;
  logic [31:0] sonuc;
  logic [31:0] sonucKayit;
  logic        gecerliOut;
`ifdef AMB_BAYRAK_EN
  logic        sifir;
  logic        esit;
`endif

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expQ[$];

  aritmetik_mantik_birimi dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .kontrol_i     (kontrol),
    .deger1_i      (deger1),
    .deger2_i      (deger2),
    .gecerli_i     (gecerliIn),
    .sonuc_o       (sonuc),
    .sonuc_kayit_o (sonucKayit),
`ifdef AMB_BAYRAK_EN
    .sifir_o       (sifir),
    .esit_o        (esit),
`endif
    .gecerli_o     (gecerliOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string isim, input logic [31:0] gercek, input logic [31:0] beklenen);
    assertCount++;
    if (gercek !== beklenen) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", isim, gercek, beklenen);
    end
  endtask

  // Drive one valid operation, check the combinational result, queue the registered one.
  task automatic applyStimulus(input string isim, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] beklenen);
    @(negedge clk);
    kontrol   = op;
    deger1    = a;
    deger2    = b;
    gecerliIn = 1'b1;
    #1;
    checkOutput(isim, sonuc, beklenen);
`ifdef AMB_BAYRAK_EN
    checkOutput({isim, "_sifir"}, {31'b0, sifir}, {31'b0, (beklenen == 32'h0)});
    checkOutput({isim, "_esit"},  {31'b0, esit},  {31'b0, (a == b)});
`endif
    expQ.push_back(beklenen);
  endtask

  always @(negedge clk) begin
    if (!rst && gecerliOut) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL kayit_unexpected: got valid %08h expected no valid", sonucKayit);
      end else begin
        checkOutput("kayit", sonucKayit, expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    kontrol   = AMB_TOPLAMA;
    deger1    = 32'h0;
    deger2    = 32'h0;
    gecerliIn = 1'b0;
    #1;
    checkOutput("reset_kayit",   sonucKayit, 32'h0);
    checkOutput("reset_gecerli", {31'b0, gecerliOut}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("toplama_80_70",   AMB_TOPLAMA, 32'd80, 32'd70, 32'd150);
    applyStimulus("cikarma_80_70",   AMB_CIKARMA, 32'd80, 32'd70, 32'd10);
    applyStimulus("cikarma_0_1",     AMB_CIKARMA, 32'd0,  32'd1,  32'hFFFF_FFFF);
    applyStimulus("toplama_tasma",   AMB_TOPLAMA, 32'hFFFF_FFFF, 32'd2, 32'd1);
    applyStimulus("xor",             AMB_XOR, 32'hF0F0_F0F0, 32'hFF0F_0F0F, 32'h0FFF_FFFF);
    applyStimulus("or",              AMB_OR,  32'hF0F0_F0F0, 32'hFF0F_0F0F, 32'hFFFF_FFFF);
    applyStimulus("and",             AMB_AND, 32'hF0F0_F0F0, 32'hFF0F_0F0F, 32'hF000_0000);
    applyStimulus("sll_4",           AMB_SLL, 32'hF0F0_F0F0, 32'd4,  32'h0F0F_0F00);
    applyStimulus("srl_4",           AMB_SRL, 32'hF0F0_F0F0, 32'd4,  32'h0F0F_0F0F);
    applyStimulus("sra_4",           AMB_SRA, 32'hF0F0_F0F0, 32'd4,  32'hFF0F_0F0F);
    applyStimulus("sra_36",          AMB_SRA, 32'hF0F0_F0F0, 32'd36, 32'hFF0F_0F0F);
    applyStimulus("sll_0",           AMB_SLL, 32'h1234_5678, 32'd0,  32'h1234_5678);
    applyStimulus("sll_33",          AMB_SLL, 32'h0000_0001, 32'd33, 32'h0000_0002);
    applyStimulus("srl_31",          AMB_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001);
    applyStimulus("sra_31_neg",      AMB_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    applyStimulus("slt_neg_pos",     AMB_SLT,  32'hF0F0_F0F0, 32'd4, 32'd1);
    applyStimulus("sltu_neg_pos",    AMB_SLTU, 32'hF0F0_F0F0, 32'd4, 32'd0);
    applyStimulus("slt_equal",       AMB_SLT,  32'd5, 32'd5, 32'd0);
    applyStimulus("slt_min_max",     AMB_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
    applyStimulus("sltu_min_max",    AMB_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
    applyStimulus("gecir",           AMB_GECIR, 32'hF0F0_F0F0, 32'd4, 32'h0000_0004);
    applyStimulus("undefined_13",    4'd13, 32'hF0F0_F0F0, 32'd4, 32'h0);
    applyStimulus("undefined_15",    4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    applyStimulus("kayit_1_2", AMB_TOPLAMA, 32'd1, 32'd2, 32'd3);
    @(negedge clk);
    gecerliIn = 1'b0;
    deger1    = 32'd40;
    @(negedge clk);
    #1;
    checkOutput("hold_gecerli", {31'b0, gecerliOut}, 32'h0);
    checkOutput("hold_kayit",   sonucKayit, 32'd3);

    // Reset between edges drops the result that was just captured.
    applyStimulus("toplama_5_6", AMB_TOPLAMA, 32'd5, 32'd6, 32'd11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async_rst_kayit",   sonucKayit, 32'h0);
    checkOutput("async_rst_gecerli", {31'b0, gecerliOut}, 32'h0);
    checkOutput("rst_sonuc_hold",    sonuc, 32'd11);
    deger1 = 32'd10;
    #1;
    checkOutput("rst_sonuc_track",   sonuc, 32'd16);
    @(negedge clk);
    rst       = 1'b0;
    gecerliIn = 1'b0;

    applyStimulus("post_rst_7_8", AMB_TOPLAMA, 32'd7, 32'd8, 32'd15);
    @(negedge clk);
    gecerliIn = 1'b0;
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    @(negedge clk);
    #1;
    checkOutput("final_gecerli", {31'b0, gecerliOut}, 32'h0);
    checkOutput("final_kayit",   sonucKayit, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/aritmetik_mantik_birimi.md
Name: aritmetik_mantik_birimi

Overview:
- 32-bit RV32I-style integer ALU in the core's execute stage.
- The result path is purely combinational, so `sonuc_o` is valid in the same cycle as the operands.
- A clocked shadow stage registers the result for the next pipeline stage, qualified by a valid bit.
- Opcode constants are shared with the decoder through the common definitions package.

Parameters:
- VERI_GENISLIGI, 32, operand/result width; only 32 is supported, and shift amounts use bits [4:0].

Ports:
- clk_i  input  1  clock; all register updates occur on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- kontrol_i  input  4  operation select (AMB_* code).
- deger1_i  input  32  operand 1 (rs1 / PC).
- deger2_i  input  32  operand 2 (rs2 / immediate / shift amount).
- gecerli_i  input  1  operands valid this cycle; enables the registered stage.
- sonuc_o  output  32  combinational result.
- sonuc_kayit_o  output  32  registered result.
- gecerli_o  output  1  registered-result valid.

Behaviour:
- Opcode encoding, in the shared package:
  - AMB_TOPLAMA=0, AMB_CIKARMA=1, AMB_XOR=2, AMB_OR=3, AMB_AND=4, AMB_SLL=5
  - AMB_SRL=6, AMB_SRA=7, AMB_SLT=8, AMB_SLTU=9, AMB_GECIR=10
  - codes 11..15 are undefined.
- Combinational `sonuc_o`, zero latency, recomputed on any input change:
  - TOPLAMA: deger1+deger2, modulo 2^32; carry is discarded.
  - CIKARMA: deger1-deger2, modulo 2^32; wraps, e.g. 0-1 = FFFF_FFFF.
  - XOR, OR, AND: bitwise.
  - SLL and SRL: logical shift of deger1 by deger2[4:0]; bits [31:5] of deger2 are ignored.
  - SRA: arithmetic right shift by deger2[4:0]; the sign bit is replicated.
  - SLT: result is 1 if deger1 < deger2 as signed two's complement, else 0; bits [31:1] are 0.
  - SLTU: same as SLT but unsigned comparison.
  - GECIR: result = deger2 (pass-through for LUI-style immediates).
  - Undefined codes: result = 0. No latches are allowed; every path assigns.
- Registered stage:
  - On a clock edge with gecerli_i=1: sonuc_kayit_o <= sonuc_o and gecerli_o <= 1.
  - With gecerli_i=0: gecerli_o <= 0 and sonuc_kayit_o holds its value.
  - Latency is one cycle. There is no backpressure; every valid input produces exactly one gecerli_o pulse one cycle later.
- Reset:
  - rst_i=1 asynchronously forces sonuc_kayit_o=0 and gecerli_o=0, immediately and regardless of the clock.
  - Reset mid-operation drops any pending result.
  - `sonuc_o` is unaffected by reset because it is combinational.
  - The first edge after reset deassertion behaves normally.
- Boundary cases:
  - Shift by 0 returns deger1 unchanged.
  - SRA by 31 of a negative value gives FFFF_FFFF.
  - SLT with equal operands gives 0.
  - SLT(8000_0000, 7FFF_FFFF) = 1; SLTU of the same operands = 0.

Optional Feature:
- Macro: AMB_BAYRAK_EN.
- When defined, adds two outputs:
  - sifir_o (1 bit): combinational, 1 when sonuc_o == 0.
  - esit_o (1 bit): combinational, 1 when deger1_i == deger2_i.
- These outputs support branch resolution.
- When undefined, neither port exists and no comparison logic is synthesized; all other behaviour is identical.

Decomposition:
- Shared package/header tanimlamalar holds:
  - the AMB_* opcode constants above;
  - the opcode width (4);
  - the data width (32).
- One natural sub-module: amb_kaydirici, a 32-bit shifter handling SLL/SRL/SRA from a 5-bit amount and a 2-bit mode.
- The adder/subtractor, logic operations, comparisons and the output register stay in the top level.

Test Plan:
- TOPLAMA 80,70 -> 150; CIKARMA 80,70 -> 10; CIKARMA 0,1 -> FFFF_FFFF.
- With operands F0F0_F0F0 and FF0F_0F0F: XOR -> 0FFF_FFFF, OR -> FFFF_FFFF, AND -> F000_0000.
- Shifting F0F0_F0F0 by 4: SLL -> 0F0F_0F00, SRL -> 0F0F_0F0F, SRA -> FF0F_0F0F.
  - Also: SRA by 36 (amount 4 after masking) -> FF0F_0F0F.
- SLT F0F0_F0F0,4 -> 1; SLTU F0F0_F0F0,4 -> 0; GECIR F0F0_F0F0,4 -> 0000_0004; opcode 13 -> 0.
- Registered path:
  - gecerli_i=1 with TOPLAMA 1,2 -> next edge gives sonuc_kayit_o=3 and gecerli_o=1.
  - gecerli_i=0 -> gecerli_o=0 and sonuc_kayit_o holds 3.
- Reset: assert rst_i between clock edges -> sonuc_kayit_o=0 and gecerli_o=0 immediately; `sonuc_o` still tracks the inputs.
